// File: rtl/plic_irq_sequencer.sv
// rtl/plic_irq_sequencer.sv - hart-side PLIC claim/complete sequencer with hold-off and debug counters
// Optional service timeout is built only when PLIC_SEQ_TIMEOUT_EN is defined.
module plic_irq_sequencer #(
  parameter int SRC_ID_WIDTH   = 3,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    irq_en_i,
  input  logic                    ext_irq_i,
  input  logic [SRC_ID_WIDTH-1:0] claim_id_i,
  output logic                    claim_req_o,
  output logic                    complete_o,
  output logic                    irq_valid_o,
  output logic [SRC_ID_WIDTH-1:0] irq_id_o,
  input  logic                    irq_ready_i,
  input  logic                    irq_done_i,
  output logic                    busy_o,
  output logic                    spurious_o,
  output logic                    timeout_o,
  output logic [CNT_WIDTH-1:0]    serviced_cnt_o,
  output logic [CNT_WIDTH-1:0]    spurious_cnt_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLAIM    = 3'd1,
    WAIT_ID  = 3'd2,
    DISPATCH = 3'd3,
    SERVICE  = 3'd4,
    COMPLETE = 3'd5,
    HOLDOFF  = 3'd6
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_hold;
  logic [SRC_ID_WIDTH-1:0] r_irq_id;
  logic                    r_spurious;
  logic [CNT_WIDTH-1:0]    r_serviced_cnt;
  logic [CNT_WIDTH-1:0]    r_spurious_cnt;
  logic                    w_id_zero;

  assign w_id_zero = (claim_id_i == '0);

`ifdef PLIC_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tcnt;
  logic        r_timeout;
  logic        w_tcnt_hit;
  logic        w_timeout_hit;

  assign w_tcnt_hit = (r_tcnt == TO_LAST);

  // Cleared throughout DISPATCH so it starts at 0 on the first SERVICE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tcnt <= 16'd0;
    end else if (r_state == DISPATCH) begin
      r_tcnt <= 16'd0;
    end else if (r_state == SERVICE && !irq_done_i) begin
      r_tcnt <= r_tcnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
`ifdef PLIC_SEQ_TIMEOUT_EN
    w_timeout_hit = 1'b0;
`endif
    case (r_state)
      IDLE:     if (ext_irq_i && irq_en_i) w_next = CLAIM;
      CLAIM:    w_next = WAIT_ID;
      WAIT_ID:  w_next = w_id_zero ? HOLDOFF : DISPATCH;
      DISPATCH: if (irq_ready_i) w_next = SERVICE;
      SERVICE: begin
        if (irq_done_i) begin
          w_next = COMPLETE;
`ifdef PLIC_SEQ_TIMEOUT_EN
        end else if (w_tcnt_hit) begin
          w_next        = COMPLETE;
          w_timeout_hit = 1'b1;
`endif
        end
      end
      COMPLETE: w_next = HOLDOFF;
      HOLDOFF:  if (r_hold == 4'd0) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Loaded on entry so HOLDOFF lasts exactly HOLDOFF_CYCLES cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold <= 4'd0;
    end else if (w_next == HOLDOFF && r_state != HOLDOFF) begin
      r_hold <= HOLD_LAST;
    end else if (r_state == HOLDOFF && r_hold != 4'd0) begin
      r_hold <= r_hold - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_id       <= '0;
      r_spurious     <= 1'b0;
      r_serviced_cnt <= '0;
      r_spurious_cnt <= '0;
    end else begin
      r_spurious <= (r_state == WAIT_ID) && w_id_zero;
      if (r_state == WAIT_ID && !w_id_zero) begin
        r_irq_id <= claim_id_i;
      end
      if (r_state == WAIT_ID && w_id_zero) begin
        r_spurious_cnt <= r_spurious_cnt + CNT_WIDTH'(1);
      end
      if (r_state == COMPLETE) begin
        r_serviced_cnt <= r_serviced_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign claim_req_o    = (r_state == CLAIM);
  assign complete_o     = (r_state == COMPLETE);
  assign irq_valid_o    = (r_state == DISPATCH);
  assign busy_o         = (r_state != IDLE);
  assign irq_id_o       = r_irq_id;
  assign spurious_o     = r_spurious;
  assign serviced_cnt_o = r_serviced_cnt;
  assign spurious_cnt_o = r_spurious_cnt;

endmodule

// File: tb/tb_plic_irq_sequencer.sv
// tb/tb_plic_irq_sequencer.sv - directed self-checking bench for plic_irq_sequencer
// Exercises PLIC_SEQ_TIMEOUT_EN behaviour in whichever build is compiled.
module tb_plic_irq_sequencer;

  localparam int SRC_W = 3;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             irq_en_i;
  logic             ext_irq_i;
  logic [SRC_W-1:0] claim_id_i;
  logic             claim_req_o;
  logic             complete_o;
  logic             irq_valid_o;
  logic [SRC_W-1:0] irq_id_o;
  logic             irq_ready_i;
  logic             irq_done_i;
  logic             busy_o;
  logic             spurious_o;
  logic             timeout_o;
  logic [CNT_W-1:0] serviced_cnt_o;
  logic [CNT_W-1:0] spurious_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  plic_irq_sequencer #(
    .SRC_ID_WIDTH  (SRC_W),
    .HOLDOFF_CYCLES(2),
    .CNT_WIDTH     (CNT_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .irq_en_i      (irq_en_i),
    .ext_irq_i     (ext_irq_i),
    .claim_id_i    (claim_id_i),
    .claim_req_o   (claim_req_o),
    .complete_o    (complete_o),
    .irq_valid_o   (irq_valid_o),
    .irq_id_o      (irq_id_o),
    .irq_ready_i   (irq_ready_i),
    .irq_done_i    (irq_done_i),
    .busy_o        (busy_o),
    .spurious_o    (spurious_o),
    .timeout_o     (timeout_o),
    .serviced_cnt_o(serviced_cnt_o),
    .spurious_cnt_o(spurious_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fast path: ready and done already high, one full service plus hold-off.
  task automatic do_service(input logic [SRC_W-1:0] id);
    ext_irq_i   = 1'b1;
    claim_id_i  = id;
    irq_ready_i = 1'b1;
    irq_done_i  = 1'b1;
    tick();
    ext_irq_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("svc_complete", {31'd0, complete_o}, 32'd1);
    irq_done_i = 1'b0;
    tick();
    tick();
    tick();
    chk("svc_idle", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_i       = 1'b1;
    irq_en_i    = 1'b1;
    ext_irq_i   = 1'b0;
    claim_id_i  = '0;
    irq_ready_i = 1'b0;
    irq_done_i  = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", {claim_req_o, complete_o, irq_valid_o, busy_o, spurious_o, timeout_o}, 32'd0);
    chk("rst_id", {29'd0, irq_id_o}, 32'd0);
    chk("rst_cnts", {24'd0, serviced_cnt_o, spurious_cnt_o}, 32'd0);
    rst_i = 1'b0;

    // Basic service, id 5, immediate ready/done
    ext_irq_i   = 1'b1;
    claim_id_i  = 3'd5;
    irq_ready_i = 1'b1;
    tick();
    chk("basic_claim", {30'd0, claim_req_o, busy_o}, 32'd3);
    ext_irq_i = 1'b0;
    tick();
    chk("basic_claim_once", {31'd0, claim_req_o}, 32'd0);
    chk("basic_no_valid_early", {31'd0, irq_valid_o}, 32'd0);
    tick();
    chk("basic_valid", {31'd0, irq_valid_o}, 32'd1);
    chk("basic_id", {29'd0, irq_id_o}, 32'd5);
    tick();
    chk("basic_valid_drop", {31'd0, irq_valid_o}, 32'd0);
    irq_done_i = 1'b1;
    tick();
    chk("basic_complete", {30'd0, complete_o, claim_req_o}, 32'd2);
    irq_done_i = 1'b0;
    tick();
    chk("basic_complete_once", {31'd0, complete_o}, 32'd0);
    chk("basic_serviced", {28'd0, serviced_cnt_o}, 32'd1);
    chk("basic_hold1", {31'd0, busy_o}, 32'd1);
    tick();
    chk("basic_hold2", {31'd0, busy_o}, 32'd1);
    tick();
    chk("basic_idle", {31'd0, busy_o}, 32'd0);

    // Spurious claim
    ext_irq_i  = 1'b1;
    claim_id_i = 3'd0;
    tick();
    chk("spur_claim", {31'd0, claim_req_o}, 32'd1);
    ext_irq_i = 1'b0;
    tick();
    tick();
    chk("spur_pulse", {31'd0, spurious_o}, 32'd1);
    chk("spur_cnt", {28'd0, spurious_cnt_o}, 32'd1);
    chk("spur_no_valid_complete", {30'd0, irq_valid_o, complete_o}, 32'd0);
    chk("spur_id_held", {29'd0, irq_id_o}, 32'd5);
    tick();
    chk("spur_pulse_once", {30'd0, spurious_o, busy_o}, 32'd1);
    tick();
    chk("spur_idle", {31'd0, busy_o}, 32'd0);
    chk("spur_serviced_same", {28'd0, serviced_cnt_o}, 32'd1);

    // Backpressure, done ignored in DISPATCH, ext held through hold-off
    ext_irq_i   = 1'b1;
    claim_id_i  = 3'd3;
    irq_ready_i = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_id", {28'd0, irq_valid_o, irq_id_o}, 32'h0b);
      irq_done_i = (i == 4);
      tick();
    end
    irq_done_i  = 1'b0;
    chk("bp_still_dispatch", {31'd0, irq_valid_o}, 32'd1);
    irq_ready_i = 1'b1;
    tick();
    chk("bp_service", {30'd0, irq_valid_o, complete_o}, 32'd0);
    tick();
    chk("bp_done_ignored", {30'd0, complete_o, busy_o}, 32'd1);
    irq_done_i = 1'b1;
    tick();
    chk("bp_complete", {31'd0, complete_o}, 32'd1);
    irq_done_i = 1'b0;
    tick();
    chk("bp_hold1_noclaim", {31'd0, claim_req_o}, 32'd0);
    chk("bp_serviced", {28'd0, serviced_cnt_o}, 32'd2);
    tick();
    chk("bp_hold2_noclaim", {31'd0, claim_req_o}, 32'd0);
    tick();
    chk("bp_idle_noclaim", {30'd0, claim_req_o, busy_o}, 32'd0);
    claim_id_i = 3'd0;
    tick();
    chk("bp_reclaim", {31'd0, claim_req_o}, 32'd1);
    ext_irq_i = 1'b0;
    tick();
    tick();
    chk("bp_spur_cnt", {28'd0, spurious_cnt_o}, 32'd2);
    tick();
    tick();
    chk("bp_back_idle", {31'd0, busy_o}, 32'd0);

    // Enable gating
    irq_en_i  = 1'b0;
    ext_irq_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("gate_no_claim", {30'd0, claim_req_o, busy_o}, 32'd0);
    end

    // Enable drop after IDLE does not abort
    irq_en_i   = 1'b1;
    claim_id_i = 3'd6;
    tick();
    chk("en_claim", {31'd0, claim_req_o}, 32'd1);
    irq_en_i  = 1'b0;
    ext_irq_i = 1'b0;
    tick();
    tick();
    chk("en_valid_id", {28'd0, irq_valid_o, irq_id_o}, 32'h0e);
    tick();
    irq_done_i = 1'b1;
    tick();
    chk("en_complete", {31'd0, complete_o}, 32'd1);
    irq_done_i = 1'b0;
    tick();
    tick();
    tick();
    chk("en_idle_cnt", {27'd0, busy_o, serviced_cnt_o}, 32'd3);
    irq_en_i = 1'b1;

    // Counter wrap at 2^CNT_W
    for (int i = 0; i < 12; i++) do_service(3'd1 + 3'(i % 7));
    chk("wrap_pre", {28'd0, serviced_cnt_o}, 32'd15);
    do_service(3'd7);
    chk("wrap_zero", {28'd0, serviced_cnt_o}, 32'd0);
    chk("wrap_spur_same", {28'd0, spurious_cnt_o}, 32'd2);

    // Service timeout / no-timeout
    ext_irq_i   = 1'b1;
    claim_id_i  = 3'd2;
    irq_ready_i = 1'b1;
    irq_done_i  = 1'b0;
    tick();
    ext_irq_i = 1'b0;
    tick();
    tick();
    tick();
    chk("to_service_entry", {30'd0, irq_valid_o, busy_o}, 32'd1);
`ifdef PLIC_SEQ_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_wait", {30'd0, complete_o, timeout_o}, 32'd0);
    end
    tick();
    chk("to_fire", {30'd0, complete_o, timeout_o}, 32'd3);
    tick();
    chk("to_once", {30'd0, complete_o, timeout_o}, 32'd0);
    chk("to_serviced", {28'd0, serviced_cnt_o}, 32'd1);
    tick();
    tick();
    chk("to_idle", {31'd0, busy_o}, 32'd0);
    ext_irq_i   = 1'b1;
    claim_id_i  = 3'd4;
    tick();
    ext_irq_i = 1'b0;
    tick();
    tick();
    tick();
`else
    for (int i = 0; i < 100; i++) tick();
    chk("noto_still_service", {29'd0, busy_o, complete_o, timeout_o}, 32'd4);
    chk("noto_valid_low", {31'd0, irq_valid_o}, 32'd0);
`endif

    // Reset mid-SERVICE
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_complete", {31'd0, complete_o}, 32'd0);
    end
    rst_i = 1'b0;
    chk("rst2_outputs", {claim_req_o, complete_o, irq_valid_o, busy_o, spurious_o, timeout_o}, 32'd0);
    chk("rst2_id_cnts", {21'd0, irq_id_o, serviced_cnt_o, spurious_cnt_o}, 32'd0);
    tick();
    chk("rst2_stay_idle", {30'd0, busy_o, complete_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plic_irq_sequencer.md
Name: plic_irq_sequencer

Overview:
- Hart-side claim/complete sequencer between the PLIC and the CPU interrupt-entry logic.
- Detects ext_irq, issues a one-cycle claim request, captures the returned source ID and hands it to the handler over a valid/ready handshake.
- Waits for handler completion, issues the complete pulse, then enforces a hold-off gap before the next claim.
- Counts serviced and spurious interrupts for debug/perf.

Parameters:
- SRC_ID_WIDTH, 3, width of PLIC claim ID; ID 0 means no source.
- HOLDOFF_CYCLES, 2, idle cycles forced after complete or spurious claim, range 1..15.
- CNT_WIDTH, 16, width of serviced/spurious counters.
- TIMEOUT_CYCLES, 255, service timeout limit, range 1..65535; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- irq_en_i  in  1  global interrupt enable (MIE); gates new claims only.
- ext_irq_i  in  1  PLIC ext_irq_o.
- claim_id_i  in  SRC_ID_WIDTH  PLIC claim_o; 0 means none.
- claim_req_o  out  1  one-cycle claim pulse to PLIC.
- complete_o  out  1  one-cycle complete pulse to PLIC.
- irq_valid_o  out  1  ID offered to handler.
- irq_id_o  out  SRC_ID_WIDTH  claimed source ID.
- irq_ready_i  in  1  handler accepts ID.
- irq_done_i  in  1  handler finished servicing.
- busy_o  out  1  high whenever state is not IDLE.
- spurious_o  out  1  one-cycle pulse when the claim returned ID 0.
- timeout_o  out  1  one-cycle pulse on service timeout.
- serviced_cnt_o  out  CNT_WIDTH  completes issued.
- spurious_cnt_o  out  CNT_WIDTH  spurious claims.

Behaviour:
- Single clock clk_i. Reset rst_i is synchronous, active-high; all state updates on posedge clk_i.
- Reset values: state IDLE; all pulses 0; irq_valid_o 0; irq_id_o 0; counters 0; busy_o 0.
- Reset mid-operation drops to IDLE with no complete issued. The system resets the PLIC on the same reset.
- All outputs are registered or decoded directly from state.

FSM states:
- IDLE: if ext_irq_i && irq_en_i, go to CLAIM. Otherwise stay.
- CLAIM: claim_req_o=1 for exactly this cycle. Go to WAIT_ID unconditionally.
- WAIT_ID: the PLIC registers its claim on the CLAIM edge, so claim_id_i is valid here.
  - If claim_id_i==0: pulse spurious_o next cycle, increment spurious_cnt_o, go to HOLDOFF. No complete is issued.
  - Otherwise: latch irq_id_o=claim_id_i, go to DISPATCH.
- DISPATCH: irq_valid_o=1 and irq_id_o stable until irq_ready_i. On valid&&ready go to SERVICE; irq_valid_o drops the following cycle.
- SERVICE: wait for irq_done_i. irq_done_i is sampled only in this state; done asserted during DISPATCH is ignored. On done go to COMPLETE.
- COMPLETE: complete_o=1 for exactly this cycle. Increment serviced_cnt_o. Reload hold-off counter. Go to HOLDOFF.
- HOLDOFF: down-count HOLDOFF_CYCLES and ignore ext_irq_i. At 0 go to IDLE. This covers the PLIC activeClaim-clear latency and prevents a stale ext_irq re-claim.

Rules:
- Minimum latency from ext_irq_i rising in IDLE to irq_valid_o: 2 cycles (CLAIM, WAIT_ID); valid appears on the 3rd edge.
- Minimum IDLE to IDLE for one interrupt with immediate ready/done: 5 + HOLDOFF_CYCLES cycles.
- irq_en_i deasserting after IDLE does not abort; the service in flight completes normally.
- Counters wrap from 2^CNT_WIDTH-1 to 0 silently.
- claim_req_o and complete_o are never high in the same cycle. At most one claim is outstanding.
- irq_id_o holds its last value after service and changes only in WAIT_ID with a nonzero ID.

Optional Feature:
- Macro: PLIC_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on SERVICE entry and increments each SERVICE cycle without irq_done_i.
  - When it reaches TIMEOUT_CYCLES, the block goes to COMPLETE and pulses timeout_o together with complete_o.
  - serviced_cnt_o still increments.
  - irq_done_i in the same cycle as the limit counts as normal completion; timeout_o stays 0.
- Undefined: SERVICE waits indefinitely. The timeout counter is not built. timeout_o is tied 0.

Test Plan:
- Reset check: assert rst_i for 3 cycles mid-SERVICE -> next cycle all outputs 0, busy_o=0, no complete_o pulse.
- Basic service: ext_irq_i=1, claim_id_i=5 in WAIT_ID, ready and done immediate -> claim_req_o pulse at cycle 1, irq_valid_o with irq_id_o=5, one complete_o pulse, serviced_cnt_o=1, IDLE after 2 hold-off cycles.
- Spurious claim: ext_irq_i=1, claim_id_i=0 -> spurious_o 1 cycle, spurious_cnt_o=1, no irq_valid_o, no complete_o, return to IDLE.
- Backpressure and hold-off: hold irq_ready_i=0 for 10 cycles -> irq_valid_o and irq_id_o=3 stable for all 10 cycles. Pulse irq_done_i during DISPATCH -> ignored. Hold ext_irq_i=1 through HOLDOFF -> no claim_req_o until IDLE.
- Enable gating and wrap: irq_en_i=0 with ext_irq_i=1 for 20 cycles -> no claim_req_o. Preload 65535 services with CNT_WIDTH=16 -> serviced_cnt_o wraps to 0.
- Timeout (with PLIC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8): no irq_done_i -> complete_o and timeout_o pulse together 8 cycles after SERVICE entry. Without the macro -> still in SERVICE after 100 cycles, timeout_o=0.
